// File: rtl/multi_agent_move_detector_if.sv
// Map memory read port shared by all agent evaluations.
// Timing: a request is the cycle mem_en=1 with mem_addr; the row comes back on
// mem_rdata exactly MEM_LATENCY cycles later, with no backpressure either way.
interface multi_agent_move_detector_if #(
  parameter int ROW_W    = 6,
  parameter int MAP_COLS = 80
);
  logic                mem_en;
  logic [ROW_W-1:0]    mem_addr;
  logic [MAP_COLS-1:0] mem_rdata;

  modport master (output mem_en, output mem_addr, input mem_rdata);
  modport slave  (input mem_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/multi_agent_move_detector.sv
// Time-multiplexed legal-move evaluator: per agent, reads the rows above/at/below
// through one memory port and commits all agents' move masks atomically.
module multi_agent_move_detector #(
  parameter int NUM_AGENTS  = 4,
  parameter int MAP_COLS    = 80,
  parameter int MAP_ROWS    = 60,
  parameter int COL_W       = 7,
  parameter int ROW_W       = 6,
  parameter int MEM_LATENCY = 1,
  parameter int WRAP_X      = 1,
  parameter int WRAP_Y      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_AGENTS*COL_W-1:0]   pos_x,
  input  logic [NUM_AGENTS*ROW_W-1:0]   pos_y,
  multi_agent_move_detector_if.master   mem,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_AGENTS*4-1:0]       valid_moves,
  output logic [NUM_AGENTS-1:0]         pos_err,
  output logic [1:0]                    dbg_state
);

  localparam int AGT_W = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
  localparam int WC_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [COL_W:0] X_LIMIT = (COL_W+1)'(MAP_COLS);
  localparam logic [COL_W:0] X_LAST  = (COL_W+1)'(MAP_COLS - 1);
  localparam logic [ROW_W:0] Y_LIMIT = (ROW_W+1)'(MAP_ROWS);
  localparam logic [ROW_W:0] Y_LAST  = (ROW_W+1)'(MAP_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_EVAL = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [AGT_W-1:0]        agent_q, agent_d;
  logic [1:0]              phase_q, phase_d;
  logic [WC_W-1:0]         wait_q, wait_d;
  logic [COL_W-1:0]        px_q [NUM_AGENTS];
  logic [COL_W-1:0]        px_d [NUM_AGENTS];
  logic [ROW_W-1:0]        py_q [NUM_AGENTS];
  logic [ROW_W-1:0]        py_d [NUM_AGENTS];
  logic [3:0]              sh_moves_q [NUM_AGENTS];
  logic [3:0]              sh_moves_d [NUM_AGENTS];
  logic [NUM_AGENTS-1:0]   sh_err_q, sh_err_d;
  logic [NUM_AGENTS*4-1:0] valid_moves_q, valid_moves_d;
  logic [NUM_AGENTS-1:0]   pos_err_q, pos_err_d;
  logic                    done_q, done_d;

  // Read tags travel alongside the memory latency so each returning word lands
  // in the right row buffer regardless of what the address is doing now.
  logic [MEM_LATENCY-1:0]  tag_v_q;
  logic [1:0]              tag_slot_q [MEM_LATENCY];
  logic [MAP_COLS-1:0]     above_q, same_q, below_q;

  logic [COL_W:0]          cur_x;
  logic [ROW_W:0]          cur_y;
  logic                    cur_err;
  logic [ROW_W:0]          row_above, row_below, rd_row;
  logic                    mv_r, mv_l, mv_u, mv_d;
  logic [3:0]              moves_now;

  function automatic logic pick(input logic [MAP_COLS-1:0] w, input logic [COL_W:0] idx);
    pick = 1'b0;
    for (int i = 0; i < MAP_COLS; i++) begin
      if (idx == (COL_W+1)'(i)) pick = w[i];
    end
  endfunction

  always_comb begin
    cur_x   = {1'b0, px_q[agent_q]};
    cur_y   = {1'b0, py_q[agent_q]};
    cur_err = (cur_x >= X_LIMIT) || (cur_y >= Y_LIMIT);
  end

  // Without vertical wrap an edge row re-reads itself; Up/Down are masked at eval.
  always_comb begin
    if (cur_y == '0) row_above = (WRAP_Y != 0) ? Y_LAST : cur_y;
    else             row_above = cur_y - 1'b1;
    if (cur_y == Y_LAST) row_below = (WRAP_Y != 0) ? '0 : cur_y;
    else                 row_below = cur_y + 1'b1;
    rd_row = '0;
    if (!cur_err) begin
      case (phase_q)
        2'd0:    rd_row = row_above;
        2'd1:    rd_row = cur_y;
        default: rd_row = row_below;
      endcase
    end
  end

  always_comb begin
    if (cur_x == X_LAST) mv_r = (WRAP_X != 0) ? same_q[0] : 1'b0;
    else                 mv_r = pick(same_q, cur_x + 1'b1);
    if (cur_x == '0)     mv_l = (WRAP_X != 0) ? same_q[MAP_COLS-1] : 1'b0;
    else                 mv_l = pick(same_q, cur_x - 1'b1);
    if ((cur_y == '0) && (WRAP_Y == 0))     mv_u = 1'b0;
    else                                    mv_u = pick(above_q, cur_x);
    if ((cur_y == Y_LAST) && (WRAP_Y == 0)) mv_d = 1'b0;
    else                                    mv_d = pick(below_q, cur_x);
    moves_now = cur_err ? 4'b0000 : {mv_l, mv_d, mv_u, mv_r};
  end

  always_comb begin
    state_d       = state_q;
    agent_d       = agent_q;
    phase_d       = phase_q;
    wait_d        = wait_q;
    px_d          = px_q;
    py_d          = py_q;
    sh_moves_d    = sh_moves_q;
    sh_err_d      = sh_err_q;
    valid_moves_d = valid_moves_q;
    pos_err_d     = pos_err_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < NUM_AGENTS; k++) begin
            px_d[k] = pos_x[k*COL_W +: COL_W];
            py_d[k] = pos_y[k*ROW_W +: ROW_W];
          end
          agent_d = '0;
          phase_d = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (phase_q == 2'd2) begin
          phase_d = '0;
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_q == WC_W'(MEM_LATENCY - 1)) state_d = S_EVAL;
        else                                  wait_d  = wait_q + 1'b1;
      end
      S_EVAL: begin
        sh_moves_d[agent_q] = moves_now;
        sh_err_d[agent_q]   = cur_err;
        if (agent_q == AGT_W'(NUM_AGENTS - 1)) begin
          for (int k = 0; k < NUM_AGENTS; k++) begin
            valid_moves_d[k*4 +: 4] = sh_moves_d[k];
          end
          pos_err_d = sh_err_d;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          agent_d = agent_q + 1'b1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      agent_q       <= '0;
      phase_q       <= '0;
      wait_q        <= '0;
      for (int k = 0; k < NUM_AGENTS; k++) begin
        px_q[k]       <= '0;
        py_q[k]       <= '0;
        sh_moves_q[k] <= '0;
      end
      sh_err_q      <= '0;
      valid_moves_q <= '0;
      pos_err_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      agent_q       <= agent_d;
      phase_q       <= phase_d;
      wait_q        <= wait_d;
      px_q          <= px_d;
      py_q          <= py_d;
      sh_moves_q    <= sh_moves_d;
      sh_err_q      <= sh_err_d;
      valid_moves_q <= valid_moves_d;
      pos_err_q     <= pos_err_d;
      done_q        <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) tag_slot_q[i] <= '0;
      above_q <= '0;
      same_q  <= '0;
      below_q <= '0;
    end else begin
      tag_v_q[0]    <= mem.mem_en;
      tag_slot_q[0] <= phase_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_v_q[i]    <= tag_v_q[i-1];
        tag_slot_q[i] <= tag_slot_q[i-1];
      end
      if (tag_v_q[MEM_LATENCY-1]) begin
        case (tag_slot_q[MEM_LATENCY-1])
          2'd0:    above_q <= mem.mem_rdata;
          2'd1:    same_q  <= mem.mem_rdata;
          default: below_q <= mem.mem_rdata;
        endcase
      end
    end
  end

  // The row MSB is never set for in-range rows; masking keeps a bad row off the bus.
  assign mem.mem_en   = (state_q == S_READ);
  assign mem.mem_addr = (state_q == S_READ) ? (rd_row[ROW_W-1:0] & {ROW_W{~rd_row[ROW_W]}}) : '0;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign valid_moves  = valid_moves_q;
  assign pos_err      = pos_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_multi_agent_move_detector.sv
// Runs two detector configurations side by side on one shared map and compares
// both against a rule-level move model.
module tb_multi_agent_move_detector;
  localparam int NA = 4, COLS = 80, ROWS = 60, CW = 7, RW = 6;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [NA*CW-1:0] pos_x = '0;
  logic [NA*RW-1:0] pos_y = '0;
  logic busy_a, done_a, busy_b, done_b;
  logic [NA*4-1:0] vm_a, vm_b;
  logic [NA-1:0] err_a, err_b;
  logic [1:0] st_a, st_b;

  always #5 clk = ~clk;

  multi_agent_move_detector_if #(.ROW_W(RW), .MAP_COLS(COLS)) mem_a ();
  multi_agent_move_detector_if #(.ROW_W(RW), .MAP_COLS(COLS)) mem_b ();

  // A: latency 1, horizontal wrap only. B: latency 3, vertical wrap only.
  multi_agent_move_detector #(.MEM_LATENCY(1), .WRAP_X(1), .WRAP_Y(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .pos_x(pos_x), .pos_y(pos_y), .mem(mem_a.master),
    .busy(busy_a), .done(done_a), .valid_moves(vm_a), .pos_err(err_a), .dbg_state(st_a));
  multi_agent_move_detector #(.MEM_LATENCY(3), .WRAP_X(0), .WRAP_Y(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .pos_x(pos_x), .pos_y(pos_y), .mem(mem_b.master),
    .busy(busy_b), .done(done_b), .valid_moves(vm_b), .pos_err(err_b), .dbg_state(st_b));

  logic [COLS-1:0] map_mem [ROWS];
  logic [COLS-1:0] rd_a;
  logic [COLS-1:0] rd_b [3];
  logic [RW-1:0] addr_log_a[$], addr_log_b[$];

  always @(posedge clk) begin
    rd_a     <= mem_a.mem_en ? map_mem[mem_a.mem_addr] : '0;
    rd_b[0]  <= mem_b.mem_en ? map_mem[mem_b.mem_addr] : '0;
    rd_b[1]  <= rd_b[0];
    rd_b[2]  <= rd_b[1];
    if (mem_a.mem_en) addr_log_a.push_back(mem_a.mem_addr);
    if (mem_b.mem_en) addr_log_b.push_back(mem_b.mem_addr);
  end
  assign mem_a.mem_rdata = rd_a;
  assign mem_b.mem_rdata = rd_b[2];

  int checks = 0, errors = 0;
  int px[NA], py[NA], px2[NA], py2[NA];
  logic [NA*4-1:0] exp_vm_a, exp_vm_b;
  logic [NA-1:0] exp_err_a, exp_err_b;
  logic [RW-1:0] exp_q_a[$], exp_q_b[$];
  int base_a, base_b, lat_a, lat_b, lat2_a, done_cnt_a, done_cnt_b, busy_cnt_a, busy_cnt_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_bit(input logic [COLS-1:0] w, input int idx);
    logic [COLS-1:0] t;
    t = w >> idx;
    return t[0];
  endfunction

  // Returns {err, Left, Down, Up, Right} straight from the movement rules.
  function automatic logic [4:0] ref_agent(input int x, input int y, input bit wx, input bit wy);
    logic r, l, u, d;
    if (x >= COLS || y >= ROWS) return 5'b10000;
    r = (x == COLS-1) ? (wx ? get_bit(map_mem[y], 0) : 1'b0) : get_bit(map_mem[y], x+1);
    l = (x == 0) ? (wx ? get_bit(map_mem[y], COLS-1) : 1'b0) : get_bit(map_mem[y], x-1);
    u = (y == 0) ? (wy ? get_bit(map_mem[ROWS-1], x) : 1'b0) : get_bit(map_mem[y-1], x);
    d = (y == ROWS-1) ? (wy ? get_bit(map_mem[0], x) : 1'b0) : get_bit(map_mem[y+1], x);
    return {1'b0, l, d, u, r};
  endfunction

  task automatic predict();
    logic [4:0] r;
    int up, dn;
    exp_q_a.delete();
    exp_q_b.delete();
    for (int k = 0; k < NA; k++) begin
      r = ref_agent(px[k], py[k], 1'b1, 1'b0);
      exp_vm_a[k*4 +: 4] = r[3:0];
      exp_err_a[k] = r[4];
      r = ref_agent(px[k], py[k], 1'b0, 1'b1);
      exp_vm_b[k*4 +: 4] = r[3:0];
      exp_err_b[k] = r[4];
      if (px[k] >= COLS || py[k] >= ROWS) begin
        repeat (3) begin exp_q_a.push_back('0); exp_q_b.push_back('0); end
      end else begin
        up = (py[k] == 0) ? py[k] : py[k] - 1;
        dn = (py[k] == ROWS-1) ? py[k] : py[k] + 1;
        exp_q_a.push_back(RW'(up)); exp_q_a.push_back(RW'(py[k])); exp_q_a.push_back(RW'(dn));
        up = (py[k] == 0) ? ROWS-1 : py[k] - 1;
        dn = (py[k] == ROWS-1) ? 0 : py[k] + 1;
        exp_q_b.push_back(RW'(up)); exp_q_b.push_back(RW'(py[k])); exp_q_b.push_back(RW'(dn));
      end
    end
  endtask

  task automatic drive_pos();
    for (int k = 0; k < NA; k++) begin
      pos_x[k*CW +: CW] = CW'(px[k]);
      pos_y[k*RW +: RW] = RW'(py[k]);
    end
  endtask

  task automatic fill_map(input logic [COLS-1:0] v);
    for (int r = 0; r < ROWS; r++) map_mem[r] = v;
  endtask

  function automatic int addr_bad_a();
    int bad = 0;
    if (addr_log_a.size() != base_a + exp_q_a.size()) return 999;
    foreach (exp_q_a[i]) if (addr_log_a[base_a+i] !== exp_q_a[i]) bad++;
    return bad;
  endfunction

  function automatic int addr_bad_b();
    int bad = 0;
    if (addr_log_b.size() != base_b + exp_q_b.size()) return 999;
    foreach (exp_q_b[i]) if (addr_log_b[base_b+i] !== exp_q_b[i]) bad++;
    return bad;
  endfunction

  // One start pulse, then a fixed observation window; c counts edges after the start edge.
  task automatic run_eval(input int disturb_at, input bit restart);
    base_a = addr_log_a.size(); base_b = addr_log_b.size();
    lat_a = -1; lat_b = -1; lat2_a = -1;
    done_cnt_a = 0; done_cnt_b = 0; busy_cnt_a = 0; busy_cnt_b = 0;
    drive_pos();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 48; c++) begin
      if (busy_a) busy_cnt_a++;
      if (busy_b) busy_cnt_b++;
      if (done_a) begin
        done_cnt_a++;
        if (lat_a < 0) lat_a = c; else if (lat2_a < 0) lat2_a = c;
      end
      if (done_b) begin done_cnt_b++; if (lat_b < 0) lat_b = c; end
      start = 1'b0;
      if (c == disturb_at) begin
        start = 1'b1;
        pos_x = (NA*CW)'($urandom);
        pos_y = (NA*RW)'($urandom);
      end
      if (restart && c == 20) begin
        px = px2; py = py2;
        drive_pos();
        start = 1'b1;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy_a, done_a, vm_a, err_a, mem_a.mem_en, mem_a.mem_addr, st_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: got busy=%b done=%b vm=%h err=%b en=%b addr=%0d st=%0d exp all zero",
               busy_a, done_a, vm_a, err_a, mem_a.mem_en, mem_a.mem_addr, st_a);
    end
    checks++;
    if ({busy_b, done_b, vm_b, err_b, mem_b.mem_en, mem_b.mem_addr, st_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got busy=%b done=%b vm=%h err=%b en=%b addr=%0d st=%0d exp all zero",
               busy_b, done_b, vm_b, err_b, mem_b.mem_en, mem_b.mem_addr, st_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_all_ones();
    fill_map('1);
    px = '{10, 20, 40, 70}; py = '{10, 5, 30, 50};
    predict();
    run_eval(-1, 1'b0);
    checks++; if (vm_a !== 16'hFFFF) begin errors++; $display("FAIL all_ones vm_a: got %h exp ffff", vm_a); end
    checks++; if (vm_b !== exp_vm_b) begin errors++; $display("FAIL all_ones vm_b: got %h exp %h", vm_b, exp_vm_b); end
    checks++; if (lat_a != 20 || done_cnt_a != 1) begin errors++; $display("FAIL all_ones done_a: lat %0d cnt %0d exp 20/1", lat_a, done_cnt_a); end
    checks++; if (lat_b != 28 || done_cnt_b != 1) begin errors++; $display("FAIL all_ones done_b: lat %0d cnt %0d exp 28/1", lat_b, done_cnt_b); end
    checks++; if (busy_cnt_a != 20) begin errors++; $display("FAIL all_ones busy_a: got %0d cycles exp 20", busy_cnt_a); end
    checks++; if (busy_cnt_b != 28) begin errors++; $display("FAIL all_ones busy_b: got %0d cycles exp 28", busy_cnt_b); end
    checks++; if (addr_bad_a() != 0) begin errors++; $display("FAIL all_ones addr_a: %0d bad entries exp 0", addr_bad_a()); end
  endtask

  task automatic test_left_only();
    fill_map('0);
    map_mem[10] = '1;
    map_mem[10][11] = 1'b0;
    px = '{10, 20, 40, 70}; py = '{10, 5, 30, 50};
    predict();
    run_eval(-1, 1'b0);
    checks++; if (vm_a[3:0] !== 4'b1000) begin errors++; $display("FAIL left_only agent0_a: got %b exp 1000", vm_a[3:0]); end
    checks++; if (vm_a !== exp_vm_a) begin errors++; $display("FAIL left_only vm_a: got %h exp %h", vm_a, exp_vm_a); end
    checks++; if (vm_b !== exp_vm_b) begin errors++; $display("FAIL left_only vm_b: got %h exp %h", vm_b, exp_vm_b); end
  endtask

  task automatic test_wrap_x();
    fill_map('0);
    map_mem[10][79] = 1'b1;
    px = '{0, 20, 40, 79}; py = '{10, 5, 30, 10};
    predict();
    run_eval(-1, 1'b0);
    checks++; if (vm_a[3:0] !== 4'b1000) begin errors++; $display("FAIL wrap_x agent0_a: got %b exp 1000", vm_a[3:0]); end
    checks++; if (vm_b[3:0] !== 4'b0000) begin errors++; $display("FAIL wrap_x agent0_b: got %b exp 0000", vm_b[3:0]); end
    checks++; if (vm_a !== exp_vm_a) begin errors++; $display("FAIL wrap_x vm_a: got %h exp %h", vm_a, exp_vm_a); end
    checks++; if (vm_b !== exp_vm_b) begin errors++; $display("FAIL wrap_x vm_b: got %h exp %h", vm_b, exp_vm_b); end
  endtask

  task automatic test_wrap_y();
    fill_map('1);
    px = '{5, 20, 40, 70}; py = '{0, 5, 59, 50};
    predict();
    run_eval(-1, 1'b0);
    checks++; if (vm_a[3:0] !== 4'b1101) begin errors++; $display("FAIL wrap_y agent0_a: got %b exp 1101", vm_a[3:0]); end
    checks++; if (vm_b[3:0] !== 4'b1111) begin errors++; $display("FAIL wrap_y agent0_b: got %b exp 1111", vm_b[3:0]); end
    checks++; if (vm_a !== exp_vm_a) begin errors++; $display("FAIL wrap_y vm_a: got %h exp %h", vm_a, exp_vm_a); end
    checks++;
    if (addr_log_a.size() < base_a + 3 || addr_log_a[base_a] !== 6'd0 || addr_log_a[base_a+1] !== 6'd0 || addr_log_a[base_a+2] !== 6'd1) begin
      errors++; $display("FAIL wrap_y addr_seq_a: first three rows wrong, exp 0,0,1");
    end
    checks++;
    if (addr_log_b.size() < base_b + 3 || addr_log_b[base_b] !== 6'd59 || addr_log_b[base_b+1] !== 6'd0 || addr_log_b[base_b+2] !== 6'd1) begin
      errors++; $display("FAIL wrap_y addr_seq_b: first three rows wrong, exp 59,0,1");
    end
    checks++; if (addr_bad_b() != 0) begin errors++; $display("FAIL wrap_y addr_b: %0d bad entries exp 0", addr_bad_b()); end
  endtask

  task automatic test_pos_err_and_ignore();
    fill_map('1);
    px = '{10, 85, 40, 70}; py = '{10, 10, 30, 61};
    predict();
    run_eval(5, 1'b0);
    checks++; if (err_a !== 4'b1010) begin errors++; $display("FAIL pos_err err_a: got %b exp 1010", err_a); end
    checks++; if (err_b !== exp_err_b) begin errors++; $display("FAIL pos_err err_b: got %b exp %b", err_b, exp_err_b); end
    checks++; if (vm_a !== 16'h0F0F) begin errors++; $display("FAIL pos_err vm_a: got %h exp 0f0f", vm_a); end
    checks++; if (vm_b !== exp_vm_b) begin errors++; $display("FAIL pos_err vm_b: got %h exp %h", vm_b, exp_vm_b); end
    checks++; if (done_cnt_a != 1 || lat_a != 20) begin errors++; $display("FAIL pos_err ignore_start_a: lat %0d cnt %0d exp 20/1", lat_a, done_cnt_a); end
    checks++; if (addr_bad_a() != 0) begin errors++; $display("FAIL pos_err addr_a: %0d bad entries exp 0", addr_bad_a()); end
  endtask

  task automatic test_back_to_back();
    logic [NA*4-1:0] first_vm_b;
    for (int r = 0; r < ROWS; r++) map_mem[r] = {$urandom, $urandom, $urandom};
    px = '{3, 0, 79, 50}; py = '{7, 20, 59, 0};
    px2 = '{79, 44, 12, 0}; py2 = '{33, 0, 58, 59};
    predict();
    first_vm_b = exp_vm_b;
    run_eval(-1, 1'b1);
    predict();
    checks++; if (lat_a != 20 || lat2_a != 41 || done_cnt_a != 2) begin
      errors++; $display("FAIL back_to_back done_a: lat %0d/%0d cnt %0d exp 20/41/2", lat_a, lat2_a, done_cnt_a); end
    checks++; if (vm_a !== exp_vm_a) begin errors++; $display("FAIL back_to_back vm_a: got %h exp %h", vm_a, exp_vm_a); end
    checks++; if (done_cnt_b != 1 || vm_b !== first_vm_b) begin
      errors++; $display("FAIL back_to_back busy_b: cnt %0d vm %h exp 1 / %h", done_cnt_b, vm_b, first_vm_b); end
  endtask

  task automatic test_reset_mid_run();
    int stray_done = 0;
    fill_map('1);
    px = '{10, 20, 40, 70}; py = '{10, 5, 30, 50};
    drive_pos();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy_a, done_a, vm_a, err_a, mem_a.mem_en, busy_b, done_b, vm_b, err_b, mem_b.mem_en} !== '0) begin
      errors++; $display("FAIL reset_mid: outputs not cleared, vm_a=%h vm_b=%h busy=%b%b", vm_a, vm_b, busy_a, busy_b);
    end
    repeat (3) begin tick(); if (done_a || done_b) stray_done++; end
    rst = 1'b0;
    repeat (30) begin tick(); if (done_a || done_b || busy_a || busy_b) stray_done++; end
    checks++; if (stray_done != 0) begin errors++; $display("FAIL reset_mid no_done: got %0d stray cycles exp 0", stray_done); end
    map_mem[5] = '0;
    map_mem[31][40] = 1'b0;
    predict();
    run_eval(-1, 1'b0);
    checks++; if (lat_b != 28 || vm_b !== exp_vm_b) begin
      errors++; $display("FAIL reset_mid rerun_b: lat %0d vm %h exp 28 / %h", lat_b, vm_b, exp_vm_b); end
    checks++; if (vm_a !== exp_vm_a) begin errors++; $display("FAIL reset_mid rerun_a: got %h exp %h", vm_a, exp_vm_a); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 15; it++) begin
      for (int r = 0; r < ROWS; r++) map_mem[r] = {$urandom, $urandom, $urandom};
      for (int k = 0; k < NA; k++) begin
        case ($urandom_range(0, 5))
          0:       px[k] = 0;
          1:       px[k] = COLS - 1;
          2:       px[k] = $urandom_range(COLS, 127);
          default: px[k] = $urandom_range(0, COLS - 1);
        endcase
        case ($urandom_range(0, 5))
          0:       py[k] = 0;
          1:       py[k] = ROWS - 1;
          2:       py[k] = $urandom_range(ROWS, 63);
          default: py[k] = $urandom_range(0, ROWS - 1);
        endcase
      end
      predict();
      run_eval((it % 3 == 0) ? 7 : -1, 1'b0);
      checks++; if (vm_a !== exp_vm_a || err_a !== exp_err_a) begin
        errors++; $display("FAIL random[%0d] a: vm %h err %b exp %h %b", it, vm_a, err_a, exp_vm_a, exp_err_a); end
      checks++; if (vm_b !== exp_vm_b || err_b !== exp_err_b) begin
        errors++; $display("FAIL random[%0d] b: vm %h err %b exp %h %b", it, vm_b, err_b, exp_vm_b, exp_err_b); end
      checks++; if (addr_bad_a() != 0 || addr_bad_b() != 0) begin
        errors++; $display("FAIL random[%0d] addr: bad a=%0d b=%0d exp 0/0", it, addr_bad_a(), addr_bad_b()); end
    end
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) map_mem[r] = '0;
    test_reset();
    test_all_ones();
    test_left_only();
    test_wrap_x();
    test_wrap_y();
    test_pos_err_and_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
